// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: valid/ready front-end that drives a combinational ALU, waits a settle time and returns result and flags
module alu_cmd_driver #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_use_acc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic        rsp_error,
  output logic [31:0] acc,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic w_accept, w_legal, w_capture, w_arith;
  assign w_legal   = cmd_op <= 4'd8;
  assign cmd_ready = !rst && (r_state == IDLE || (r_state == RESP && rsp_ready));
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_capture = r_state == SETTLE && r_cnt == 4'd0;
  assign w_arith   = alu_op[3:1] == 3'd0;
  assign rsp_valid = r_state == RESP;
  assign busy      = r_state != IDLE;
  // State register; reset discards any in-flight command.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // Next state: an accept wins (only possible in IDLE or RESP), then capture, then a bare response handshake.
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = w_legal ? SETTLE : RESP;
    else if (w_capture) w_next = RESP;
    else if (rsp_valid && rsp_ready) w_next = IDLE;
  end
  // Operand registers, settle counter, response capture and accumulator.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      r_cnt        <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_error    <= 1'b0;
      acc          <= '0;
    end else begin
      if (w_accept && w_legal) begin
        alu_a  <= cmd_use_acc ? acc : cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
        r_cnt  <= 4'(ALU_LATENCY - 1);
      end else if (r_state == SETTLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        rsp_result   <= alu_result;
        rsp_carry    <= alu_carryout & w_arith;
        rsp_overflow <= alu_overflow & w_arith;
        rsp_zero     <= alu_zero;
        rsp_error    <= 1'b0;
        acc          <= alu_result;
      end else if (w_accept && !w_legal) begin
        rsp_result   <= '0;
        rsp_carry    <= 1'b0;
        rsp_overflow <= 1'b0;
        rsp_zero     <= 1'b0;
        rsp_error    <= 1'b1;
      end
    end
endmodule
